// File: rtl/axis_ring_mux_shim_in.sv
// axis_ring_mux_shim_in
//   Merges NUM_PORTS AXI-Stream sources onto one ring-router injection link.
//   A round-robin arbiter locks one source for a whole packet (until its tlast
//   beat has left). Each beat is parked in a one-beat holding register and
//   sent as SERIALIZATION_FACTOR flits, LSB slice first, under credit-based
//   flow control against the router's input flit buffer.
//
// State table:
//   IDLE   | no port locked; arbitrate among valid sources this cycle
//   LOCKED | port grant_idx owns the link until its tail flit is sent
//
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   axis_in_*[NUM_PORTS]        AXIS sources (tvalid/tready/tdata/tlast/tid/tdest)
//   data_out, dest_out          registered flit payload and {tid,tdest}
//   is_tail_out, send_out       registered tail marker and one-cycle flit strobe
//   credit_in                   one credit returned per cycle while high
//   credit_overflow             sticky: credit returned while already full
//   grant_idx                   currently / last granted port (debug)
module axis_ring_mux_shim_in #(
  parameter int NUM_PORTS            = 4,
  parameter int TID_WIDTH            = 2,
  parameter int TDEST_WIDTH          = 4,
  parameter int TDATA_WIDTH          = 512,
  parameter int SERIALIZATION_FACTOR = 4,
  parameter int FLIT_BUFFER_DEPTH    = 4,
  localparam int FLIT_WIDTH  = TDATA_WIDTH / SERIALIZATION_FACTOR,
  localparam int DEST_WIDTH  = TID_WIDTH + TDEST_WIDTH,
  localparam int GRANT_WIDTH = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_PORTS-1:0]   axis_in_tvalid,
  output logic [NUM_PORTS-1:0]   axis_in_tready,
  input  logic [TDATA_WIDTH-1:0] axis_in_tdata [NUM_PORTS],
  input  logic [NUM_PORTS-1:0]   axis_in_tlast,
  input  logic [TID_WIDTH-1:0]   axis_in_tid   [NUM_PORTS],
  input  logic [TDEST_WIDTH-1:0] axis_in_tdest [NUM_PORTS],
  output logic [FLIT_WIDTH-1:0]  data_out,
  output logic [DEST_WIDTH-1:0]  dest_out,
  output logic                   is_tail_out,
  output logic                   send_out,
  input  logic                   credit_in,
  output logic                   credit_overflow,
  output logic [GRANT_WIDTH-1:0] grant_idx
);

  localparam int CW  = $clog2(FLIT_BUFFER_DEPTH + 1);
  localparam int FCW = (SERIALIZATION_FACTOR > 1) ? $clog2(SERIALIZATION_FACTOR) : 1;
  localparam logic [CW-1:0]  CRED_FULL = CW'(FLIT_BUFFER_DEPTH);
  localparam logic [FCW-1:0] FC_LAST   = FCW'(SERIALIZATION_FACTOR - 1);

  typedef enum logic {IDLE, LOCKED} state_e;

  state_e                 state_q, state_d;
  logic [GRANT_WIDTH-1:0] gnt_q, gnt_d;
  logic [GRANT_WIDTH-1:0] rr_q, rr_d;
  logic                   hold_vld_q, hold_vld_d;
  logic [TDATA_WIDTH-1:0] hold_data_q, hold_data_d;
  logic                   hold_last_q, hold_last_d;
  logic [DEST_WIDTH-1:0]  hold_dest_q, hold_dest_d;
  logic [FCW-1:0]         fc_q, fc_d;
  logic [CW-1:0]          cred_q, cred_d;
  logic                   ovf_q, ovf_d;
  logic                   send_q, send_d;
  logic                   tail_q, tail_d;
  logic [FLIT_WIDTH-1:0]  dout_q, dout_d;
  logic [DEST_WIDTH-1:0]  dest_q, dest_d;

  logic                   send;
  logic                   fc_last;
  logic                   tready_g;
  logic                   hs;
  logic                   found;
  logic [GRANT_WIDTH-1:0] cand;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      rr_q        <= '0;
      hold_vld_q  <= 1'b0;
      hold_data_q <= '0;
      hold_last_q <= 1'b0;
      hold_dest_q <= '0;
      fc_q        <= '0;
      cred_q      <= CRED_FULL;
      ovf_q       <= 1'b0;
      send_q      <= 1'b0;
      tail_q      <= 1'b0;
      dout_q      <= '0;
      dest_q      <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      rr_q        <= rr_d;
      hold_vld_q  <= hold_vld_d;
      hold_data_q <= hold_data_d;
      hold_last_q <= hold_last_d;
      hold_dest_q <= hold_dest_d;
      fc_q        <= fc_d;
      cred_q      <= cred_d;
      ovf_q       <= ovf_d;
      send_q      <= send_d;
      tail_q      <= tail_d;
      dout_q      <= dout_d;
      dest_q      <= dest_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    rr_d        = rr_q;
    hold_vld_d  = hold_vld_q;
    hold_data_d = hold_data_q;
    hold_last_d = hold_last_q;
    hold_dest_d = hold_dest_q;
    fc_d        = fc_q;
    cred_d      = cred_q;
    ovf_d       = ovf_q;
    send_d      = 1'b0;
    tail_d      = 1'b0;
    dout_d      = dout_q;
    dest_d      = dest_q;
    found       = 1'b0;
    cand        = '0;

    send     = (state_q == LOCKED) && hold_vld_q && (cred_q != '0);
    fc_last  = (fc_q == FC_LAST);
    // The holding register can take the next beat in the same cycle its final
    // flit leaves, which keeps one flit per cycle across beat boundaries.
    tready_g = (state_q == LOCKED) &&
               (!hold_vld_q || (send && fc_last && !hold_last_q));
    hs       = tready_g && axis_in_tvalid[gnt_q];

    case (state_q)
      IDLE: begin
        for (int i = 0; i < NUM_PORTS; i++) begin
          cand = GRANT_WIDTH'((int'(rr_q) + i) % NUM_PORTS);
          if (!found && axis_in_tvalid[cand]) begin
            found   = 1'b1;
            gnt_d   = cand;
            rr_d    = GRANT_WIDTH'((int'(cand) + 1) % NUM_PORTS);
            state_d = LOCKED;
          end
        end
      end
      LOCKED: begin
        if (send && fc_last && hold_last_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (hs) begin
      hold_vld_d  = 1'b1;
      hold_data_d = axis_in_tdata[gnt_q];
      hold_last_d = axis_in_tlast[gnt_q];
      hold_dest_d = {axis_in_tid[gnt_q], axis_in_tdest[gnt_q]};
      fc_d        = '0;
    end else if (send) begin
      if (fc_last) begin
        hold_vld_d = 1'b0;
        fc_d       = '0;
      end else begin
        fc_d = FCW'(fc_q + 1'b1);
      end
    end

    // A send and a returned credit in the same cycle cancel out, so a full
    // counter with a simultaneous send is not an overflow.
    case ({send, credit_in})
      2'b10: cred_d = cred_q - 1'b1;
      2'b01: begin
        if (cred_q == CRED_FULL) ovf_d = 1'b1;
        else                     cred_d = cred_q + 1'b1;
      end
      default: ;
    endcase

    if (send) begin
      send_d = 1'b1;
      tail_d = hold_last_q && fc_last;
      dout_d = hold_data_q[int'(fc_q)*FLIT_WIDTH +: FLIT_WIDTH];
      dest_d = hold_dest_q;
    end
  end

  always_comb begin
    axis_in_tready        = '0;
    axis_in_tready[gnt_q] = tready_g;
  end

  assign data_out        = dout_q;
  assign dest_out        = dest_q;
  assign is_tail_out     = tail_q;
  assign send_out        = send_q;
  assign credit_overflow = ovf_q;
  assign grant_idx       = gnt_q;

endmodule

// File: tb/tb_axis_ring_mux_shim_in.sv
module tb_axis_ring_mux_shim_in;

  localparam int NP    = 4;
  localparam int TIDW  = 2;
  localparam int TDW   = 4;
  localparam int DATW  = 512;
  localparam int SF    = 4;
  localparam int DEPTH = 4;
  localparam int FW    = DATW / SF;
  localparam int DW    = TIDW + TDW;
  localparam int GW    = 2;

  typedef struct packed {
    logic [DATW-1:0] data;
    logic            last;
    logic [TIDW-1:0] tid;
    logic [TDW-1:0]  tdest;
  } beat_t;

  typedef struct packed {
    logic [FW-1:0] data;
    logic [DW-1:0] dest;
    logic          tail;
    logic [GW-1:0] port;
  } flit_t;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [NP-1:0]   axis_in_tvalid = '0;
  logic [NP-1:0]   axis_in_tready;
  logic [DATW-1:0] axis_in_tdata [NP];
  logic [NP-1:0]   axis_in_tlast = '0;
  logic [TIDW-1:0] axis_in_tid   [NP];
  logic [TDW-1:0]  axis_in_tdest [NP];
  logic [FW-1:0]   data_out;
  logic [DW-1:0]   dest_out;
  logic            is_tail_out;
  logic            send_out;
  logic            credit_in;
  logic            credit_overflow;
  logic [GW-1:0]   grant_idx;

  logic credit_ret = 1'b0;
  logic credit_man = 1'b0;
  assign credit_in = credit_ret | credit_man;

  always #5 clk = ~clk;

  axis_ring_mux_shim_in #(
    .NUM_PORTS(NP), .TID_WIDTH(TIDW), .TDEST_WIDTH(TDW), .TDATA_WIDTH(DATW),
    .SERIALIZATION_FACTOR(SF), .FLIT_BUFFER_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .axis_in_tvalid(axis_in_tvalid), .axis_in_tready(axis_in_tready),
    .axis_in_tdata(axis_in_tdata), .axis_in_tlast(axis_in_tlast),
    .axis_in_tid(axis_in_tid), .axis_in_tdest(axis_in_tdest),
    .data_out(data_out), .dest_out(dest_out), .is_tail_out(is_tail_out),
    .send_out(send_out), .credit_in(credit_in),
    .credit_overflow(credit_overflow), .grant_idx(grant_idx)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int owed     = 0;     // flits the downstream router has not yet credited back
  bit ret_en   = 1'b1;
  int ret_pct  = 100;
  int bubble_pct = 0;
  int sends_seen = 0;
  int run_len  = 0;
  int max_run  = 0;
  int rr_model = 0;
  int drv_done = 0;

  beat_t port_q  [NP][$];
  beat_t stage_q [NP][$];
  flit_t exp_q [$];

  task automatic chk(input bit ok, input string nm,
                     input logic [FW-1:0] act, input logic [FW-1:0] req);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: actual %0h required %0h (t=%0t)", nm, act, req, $time);
  endtask

  // Downstream router model: returns owed credits with a random delay.
  initial forever begin
    @(posedge clk); #1;
    if (ret_en && owed > 0 && int'($urandom_range(0, 99)) < ret_pct) begin
      credit_ret = 1'b1;
      owed--;
    end else begin
      credit_ret = 1'b0;
    end
  end

  // Monitor / scoreboard.
  initial forever begin
    flit_t f;
    @(negedge clk);
    if (rst_n && send_out) begin
      sends_seen++;
      owed++;
      run_len++;
      if (run_len > max_run) max_run = run_len;
      chk(owed <= DEPTH, "credit_bound", owed, DEPTH);
      if (exp_q.size() == 0) begin
        chk(1'b0, "unexpected_flit", data_out, 0);
      end else begin
        f = exp_q.pop_front();
        chk(data_out == f.data, "flit_data", data_out, f.data);
        chk(dest_out == f.dest, "flit_dest", dest_out, f.dest);
        chk(is_tail_out == f.tail, "flit_tail", is_tail_out, f.tail);
        chk(grant_idx == f.port, "flit_port", grant_idx, f.port);
      end
    end else begin
      run_len = 0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic add_packet(input int p, input int nb);
    beat_t b;
    logic [TIDW-1:0] tid;
    logic [TDW-1:0]  tdest;
    tid   = TIDW'($urandom);
    tdest = TDW'($urandom);
    for (int i = 0; i < nb; i++) begin
      for (int w = 0; w < DATW/32; w++) b.data[w*32 +: 32] = $urandom;
      b.last  = (i == nb - 1);
      b.tid   = tid;
      b.tdest = tdest;
      port_q[p].push_back(b);
      stage_q[p].push_back(b);
    end
  endtask

  // Reference: all staged packets are pending together, so packets leave in
  // pure round-robin order over ports that still have packets.
  task automatic build_model();
    beat_t b;
    flit_t f;
    int sel;
    forever begin
      sel = -1;
      for (int i = 0; i < NP; i++) begin
        int q;
        q = (rr_model + i) % NP;
        if (sel < 0 && stage_q[q].size() > 0) sel = q;
      end
      if (sel < 0) break;
      do begin
        b = stage_q[sel].pop_front();
        for (int k = 0; k < SF; k++) begin
          f.data = b.data[k*FW +: FW];
          f.dest = {b.tid, b.tdest};
          f.tail = b.last && (k == SF - 1);
          f.port = GW'(sel);
          exp_q.push_back(f);
        end
      end while (!b.last);
      rr_model = (sel + 1) % NP;
    end
  endtask

  task automatic drive_port(input int p);
    beat_t b;
    bit pkt_start;
    int t;
    pkt_start = 1'b1;
    while (port_q[p].size() > 0) begin
      b = port_q[p].pop_front();
      if (!pkt_start && int'($urandom_range(0, 99)) < bubble_pct) begin
        axis_in_tvalid[p] = 1'b0;
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
      axis_in_tvalid[p] = 1'b1;
      axis_in_tdata[p]  = b.data;
      axis_in_tlast[p]  = b.last;
      axis_in_tid[p]    = b.tid;
      axis_in_tdest[p]  = b.tdest;
      t = 0;
      forever begin
        @(negedge clk);
        if (axis_in_tready[p]) break;
        t++;
        if (t > 3000) break;
      end
      if (t > 3000) begin
        chk(1'b0, "handshake_timeout", p, 0);
        port_q[p].delete();
        break;
      end
      @(posedge clk); #1;
      pkt_start = b.last;
    end
    axis_in_tvalid[p] = 1'b0;
    drv_done++;
  endtask

  task automatic start_drivers(output int nd);
    nd = 0;
    drv_done = 0;
    build_model();
    for (int p = 0; p < NP; p++) begin
      if (port_q[p].size() > 0) begin
        nd++;
        fork
          automatic int pp = p;
          drive_port(pp);
        join_none
      end
    end
  endtask

  task automatic finish_phase(input int nd);
    int t;
    t = 0;
    while (drv_done < nd && t < 5000) begin @(posedge clk); t++; end
    chk(drv_done == nd, "drivers_done", drv_done, nd);
    t = 0;
    while (exp_q.size() > 0 && t < 5000) begin @(posedge clk); t++; end
    chk(exp_q.size() == 0, "drain", exp_q.size(), 0);
    #1;
  endtask

  task automatic wait_credits_home();
    int t;
    t = 0;
    while (owed > 0 && t < 2000) begin @(posedge clk); t++; end
    chk(owed == 0, "credits_home", owed, 0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic random_phase();
    int nd;
    bubble_pct = 30;
    ret_pct    = $urandom_range(40, 100);
    for (int p = 0; p < NP; p++) begin
      int npk;
      npk = $urandom_range(0, 2);
      for (int k = 0; k < npk; k++) add_packet(p, $urandom_range(1, 3));
    end
    start_drivers(nd);
    finish_phase(nd);
    wait_credits_home();
  endtask

  initial begin
    int nd;
    int base;
    int t;
    for (int p = 0; p < NP; p++) begin
      axis_in_tdata[p] = '0;
      axis_in_tid[p]   = '0;
      axis_in_tdest[p] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    chk(axis_in_tready == '0, "rst_tready", axis_in_tready, 0);
    chk(send_out == 1'b0, "rst_send", send_out, 0);
    chk(data_out == '0, "rst_data", data_out, 0);
    chk(dest_out == '0, "rst_dest", dest_out, 0);
    chk(is_tail_out == 1'b0, "rst_tail", is_tail_out, 0);
    chk(credit_overflow == 1'b0, "rst_ovf", credit_overflow, 0);
    chk(grant_idx == '0, "rst_grant", grant_idx, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Ports 0 and 2 contend: 0, 2, then 0 again.
    add_packet(0, 3); add_packet(0, 3); add_packet(2, 3);
    start_drivers(nd);
    finish_phase(nd);
    wait_credits_home();

    // Single 2-beat packet with prompt credit return: 8 back-to-back flits.
    bubble_pct = 0; ret_pct = 100; max_run = 0;
    add_packet(0, 2);
    start_drivers(nd);
    finish_phase(nd);
    chk(max_run == 2*SF, "burst_len", max_run, 2*SF);
    wait_credits_home();

    random_phase();

    // Credit starvation: only DEPTH flits go out, then one per returned credit.
    ret_en = 1'b0;
    base = sends_seen;
    add_packet(1, 2);
    start_drivers(nd);
    repeat (40) @(posedge clk);
    @(negedge clk); #1;
    chk(sends_seen - base == DEPTH, "starve_count", sends_seen - base, DEPTH);
    chk(axis_in_tready == '0, "starve_tready", axis_in_tready, 0);
    @(posedge clk); #1 credit_man = 1'b1; owed--;
    @(posedge clk); #1 credit_man = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    chk(sends_seen - base == DEPTH + 1, "one_credit_one_flit", sends_seen - base, DEPTH + 1);
    ret_en = 1'b1;
    finish_phase(nd);
    wait_credits_home();

    // Extra credit at full count sets the sticky overflow flag.
    chk(credit_overflow == 1'b0, "ovf_before", credit_overflow, 0);
    @(posedge clk); #1 credit_man = 1'b1;
    @(posedge clk); #1 credit_man = 1'b0;
    chk(credit_overflow == 1'b1, "ovf_set", credit_overflow, 1);
    random_phase();
    chk(credit_overflow == 1'b1, "ovf_sticky", credit_overflow, 1);

    // Reset after flit 2 of a 4-flit beat.
    bubble_pct = 0; ret_pct = 100;
    base = sends_seen;
    add_packet(3, 1);
    start_drivers(nd);
    t = 0;
    while (sends_seen - base < 2 && t < 500) begin @(negedge clk); #1; t++; end
    chk(sends_seen - base == 2, "pre_reset_flits", sends_seen - base, 2);
    rst_n = 1'b0;
    #1;
    chk(send_out == 1'b0, "async_rst_send", send_out, 0);
    chk(data_out == '0, "async_rst_data", data_out, 0);
    chk(dest_out == '0, "async_rst_dest", dest_out, 0);
    chk(credit_overflow == 1'b0, "async_rst_ovf", credit_overflow, 0);
    chk(grant_idx == '0, "async_rst_grant", grant_idx, 0);
    exp_q.delete();
    owed = 0;
    rr_model = 0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    chk(drv_done == nd, "rst_driver_done", drv_done, nd);
    @(posedge clk); #1;

    // Credits must be back at full: exactly DEPTH flits without returns.
    ret_en = 1'b0;
    base = sends_seen;
    add_packet(2, 2);
    start_drivers(nd);
    repeat (40) @(posedge clk);
    #1;
    chk(sends_seen - base == DEPTH, "post_rst_credits", sends_seen - base, DEPTH);
    ret_en = 1'b1;
    finish_phase(nd);
    wait_credits_home();
    chk(credit_overflow == 1'b0, "post_rst_ovf", credit_overflow, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/axis_ring_mux_shim_in.md
Name: axis_ring_mux_shim_in

Overview:
- Single-clock NoC injection shim. Merges NUM_PORTS AXI-Stream sources onto one ring router injection link.
- Arbitration is round-robin and packet-locked (wormhole): a granted port keeps the link until its tlast beat has gone out.
- Each AXIS beat is serialized into SERIALIZATION_FACTOR flits. Flits are sent under credit-based flow control against the router's input flit buffer.
- Successor to the per-endpoint serializer shim: adds multi-source muxing, packet-atomic arbitration and credit-overflow detection.

Parameters:
NUM_PORTS, 4, number of AXIS sources (>=1)
TID_WIDTH, 2, AXIS tid width
TDEST_WIDTH, 4, AXIS tdest width
TDATA_WIDTH, 512, AXIS beat width; must be divisible by SERIALIZATION_FACTOR
SERIALIZATION_FACTOR, 4, flits per beat (>=1; 1 = no serialization)
FLIT_BUFFER_DEPTH, 4, credits at reset = downstream router input buffer depth (>=1)
(derived) FLIT_WIDTH = TDATA_WIDTH/SERIALIZATION_FACTOR; DEST_WIDTH = TID_WIDTH+TDEST_WIDTH

Ports:
clk  in  1  NoC clock
rst_n  in  1  asynchronous active-low reset
axis_in_tvalid  in  1 [NUM_PORTS]  source valid
axis_in_tready  out  1 [NUM_PORTS]  source ready
axis_in_tdata  in  TDATA_WIDTH [NUM_PORTS]  beat data
axis_in_tlast  in  1 [NUM_PORTS]  last beat of packet
axis_in_tid  in  TID_WIDTH [NUM_PORTS]  stream id
axis_in_tdest  in  TDEST_WIDTH [NUM_PORTS]  destination
data_out  out  FLIT_WIDTH  flit payload
dest_out  out  DEST_WIDTH  {tid,tdest} of current packet, on every flit
is_tail_out  out  1  last flit of the tlast beat
send_out  out  1  flit valid, single-cycle pulse per flit
credit_in  in  1  one credit returned per cycle when high
credit_overflow  out  1  sticky error flag
grant_idx  out  $clog2(NUM_PORTS) (min 1)  currently/last granted port, debug

Behaviour:
- Reset (async assert, sync release): state=IDLE, credits=FLIT_BUFFER_DEPTH, rr pointer=0, grant_idx=0. All tready=0, send_out=0, is_tail_out=0, data_out=0, dest_out=0, credit_overflow=0.
- State machine:
  - IDLE: no port locked.
  - LOCKED: port g owns the link; the holding register may or may not contain a beat.
- Arbitration (IDLE only):
  - Choose the first port with tvalid, searching from rr pointer upward with wrap.
  - Go to LOCKED with g set. rr pointer = g+1 mod NUM_PORTS.
  - Arbitration takes 1 cycle; no tready in that cycle.
- Holding register: one beat (data, last, dest), flit counter fc in 0..SF-1.
  - axis_in_tready[g] = LOCKED && (hold empty || (final flit of held beat sent this cycle && !held.last)).
  - tready of all other ports is 0.
  - A handshake on port g loads the register and sets fc=0.
- Flit send:
  - When hold is full and credits>0: send_out=1, data_out = bits [fc*FLIT_WIDTH +: FLIT_WIDTH] (LSB slice first), dest_out = held dest.
  - is_tail_out = held.last && fc==SF-1.
  - On send: fc++. At fc==SF-1, the register empties, unless reloaded the same cycle.
- Outputs are registered: a flit appears one cycle after the send decision.
- Throughput: back-to-back beats within a packet give one flit per cycle with unlimited credits.
- Tail and re-arbitration: after the tail flit is sent, return to IDLE. The next packet's first flit is at least 2 cycles after the tail.
- Credits: counter width $clog2(FLIT_BUFFER_DEPTH+1).
  - Send without credit_in: -1. credit_in without send: +1. Both in the same cycle: unchanged.
  - credits==0: send_out stays 0, fc holds, tready[g] stays 0 until hold empties.
- Credit overflow: credit_in while credits==FLIT_BUFFER_DEPTH and no send that cycle. Counter saturates and credit_overflow sets; it clears only on reset.
- tvalid dropping while locked mid-packet: stay LOCKED and wait, no timeout; other ports starve.
- SERIALIZATION_FACTOR=1: each beat is one flit; is_tail_out = tlast.
- NUM_PORTS=1: arbitration is trivial but the 1-cycle IDLE->LOCKED step still applies.
- Reset mid-packet: partial packet is discarded, credits restored to full. The downstream router is reset by the same rst_n.

Test Plan:
- Single port, SF=4, one 2-beat packet (tlast on beat 2), credits 4, credit_in returned 2 cycles after each send -> 8 consecutive send_out pulses, slices in LSB-first order, is_tail_out only on flit 8, dest_out constant {tid,tdest}.
- Ports 0 and 2 both tvalid with 3-beat packets from reset -> port 0's 12 flits all go out before any of port 2's. grant_idx 0 then 2. Third packet on port 0 is granted only after port 2's tail (round-robin).
- credit_in held 0, FLIT_BUFFER_DEPTH=4, 2-beat packet -> exactly 4 flits sent, then send_out=0 and tready=0. One credit_in pulse -> exactly one more flit.
- Simultaneous send and credit_in every cycle with depth 1 -> credits stay 1, 1 flit/cycle sustained, no overflow.
- Extra credit_in pulse at full credits -> credit_overflow=1 next cycle and remains 1 through traffic until rst_n pulse clears it.
- rst_n asserted after flit 2 of a 4-flit beat -> outputs zero immediately (async). After release, credits=4, state IDLE, next packet starts at flit 0.
